// File: rtl/gpu_pkg.sv
// Shared GPU front-end definitions: bus widths, the HALT opcode,
// the fetch FSM state encoding and the prefetch FIFO entry layout.
package gpu_pkg;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 16;

  localparam logic [DATA_W-1:0] OP_HALT = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO for the shader fetch stage.
// The head entry and its valid flag are held in dedicated registers so the
// downstream handshake sees register outputs only.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   flush         drop every entry (wins over push)
//   push, wdata   write one entry
//   pop           head consumed this cycle (ignored when empty)
//   valid, head   registered head entry
//   count         number of stored entries, including the head
module fetch_fifo
  import gpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           wdata,
  input  logic                   pop,
  output logic                   valid,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr, rd_d, wr_d;
  logic [CW-1:0]  after_pop, count_d;
  logic           pop_ok, valid_d;
  fetch_entry_t   head_d;

  // Next pointers, occupancy and the entry that becomes head next cycle.
  always_comb begin
    pop_ok    = pop & valid;
    after_pop = count - CW'(pop_ok);
    count_d   = after_pop + CW'(push);
    rd_d      = rd_ptr + PW'(pop_ok);
    wr_d      = wr_ptr + PW'(push);
    valid_d   = 1'b0;
    head_d    = head;
    if (flush) begin
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
    end else if (after_pop != '0) begin
      valid_d = 1'b1;
      head_d  = mem[rd_d];
    end else if (push) begin
      // Empty after the pop: the incoming word goes straight to the head.
      valid_d = 1'b1;
      head_d  = wdata;
    end
  end

  // Control and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      rd_ptr <= rd_d;
      wr_ptr <= wr_d;
      count  <= count_d;
      valid  <= valid_d;
      head   <= head_d;
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  // The issue credit rule must never let a push land on a full FIFO.
  push_full_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && !pop_ok && count == CW'(DEPTH)));

endmodule

// File: rtl/shader_fetch.sv
// Shader instruction fetch stage.
// Issues addresses to a registered-read program memory, captures the word one
// cycle after it is presented, buffers it with its PC in a prefetch FIFO and
// hands it to the decoder with valid/ready. Handles start, branch redirect
// (flush + refetch) and stops issuing on the HALT word.
// Ports:
//   clk, KEY0                   clock, async active-low reset
//   start                       begin fetching at START_ADDR (idle only)
//   redirect_valid/_addr        branch taken, refetch from target
//   input_addr                  registered memory read address
//   data_input                  memory word for last cycle's address
//   instr_valid/_data/_pc       FIFO head toward the decoder
//   instr_ready                 decoder accepts head
//   busy                        fetch FSM not idle
module shader_fetch
  import gpu_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              KEY0,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] input_addr,
  input  logic [DATA_W-1:0] data_input,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              busy
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CW1 = CW + 1;

  fetch_state_e      state, state_d;
  logic [ADDR_W-1:0] pc, pc_d, addr_d, issue_addr, inflight_pc;
  logic              addr_vld, addr_vld_d, inflight, inflight_d, busy_d;
  logic              issue, push, flush, pop, halt_hit, credit_ok, drained;
  logic [CW-1:0]     fifo_count;
  fetch_entry_t      push_entry, head;

  // addr_vld: an issued address is on input_addr this cycle.
  // inflight: data_input carries the word for inflight_pc this cycle.
  // Both count against FIFO space so a push can never overflow it.
  always_comb begin
    pop        = instr_valid & instr_ready;
    halt_hit   = inflight && (data_input == OP_HALT);
    credit_ok  = (CW1'(fifo_count) + CW1'(addr_vld) + CW1'(inflight)) < CW1'(FIFO_DEPTH);
    drained    = !inflight && !addr_vld && ((fifo_count - CW'(pop)) == '0);
    push_entry = '{pc: inflight_pc, data: data_input};
  end

  // Next-state, issue and FIFO control.
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    addr_d     = input_addr;
    addr_vld_d = 1'b0;
    inflight_d = addr_vld;
    push       = inflight;
    flush      = 1'b0;
    issue      = 1'b0;
    issue_addr = pc;
    case (state)
      S_IDLE: begin
        if (redirect_valid) begin
          issue      = 1'b1;
          issue_addr = redirect_addr;
          state_d    = S_RUN;
        end else if (start) begin
          issue      = 1'b1;
          issue_addr = START_ADDR;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        // HALT is delivered; the word fetched behind it is dropped.
        if (halt_hit) begin
          state_d    = S_DRAIN;
          inflight_d = 1'b0;
        end else if (credit_ok) begin
          issue = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drained) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_valid && state != S_IDLE) begin
      flush      = 1'b1;
      push       = 1'b0;
      inflight_d = 1'b0;
      issue      = 1'b1;
      issue_addr = redirect_addr;
      state_d    = S_RUN;
    end
    if (issue) begin
      addr_d     = issue_addr;
      addr_vld_d = 1'b1;
      pc_d       = issue_addr + ADDR_W'(1);
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge KEY0) begin
    if (!KEY0) begin
      state       <= S_IDLE;
      pc          <= '0;
      input_addr  <= '0;
      addr_vld    <= 1'b0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      input_addr  <= addr_d;
      addr_vld    <= addr_vld_d;
      inflight    <= inflight_d;
      inflight_pc <= input_addr;
      busy        <= busy_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (KEY0),
    .flush (flush),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .valid (instr_valid),
    .head  (head),
    .count (fifo_count)
  );

  assign instr_data = head.data;
  assign instr_pc   = head.pc;

endmodule
